// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - main control FSM for the multicycle RV32I datapath
module multicycle_control_fsm #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic [1:0] imm_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       illegal,
    output logic       halted
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
    } state_t;

    state_t state, state_next;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        alu_op     = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default: begin
                        illegal    = 1'b1;
                        state_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                pc_write   = zero;
                state_next = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
        // Reset shows the FETCH mux setting with every strobe suppressed.
        if (rst) begin
            alu_op     = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            illegal    = 1'b0;
            halted     = 1'b0;
        end
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - randomized self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

    logic clk, rst, zero, mem_ready;
    logic [6:0] op;

    logic [1:0] alu_op0, a0, b0, rs0, imm0, alu_op1, a1, b1, rs1, imm1;
    logic adr0, ir0, pc0, rw0, mw0, ill0, hlt0;
    logic adr1, ir1, pc1, rw1, mw1, ill1, hlt1;

    multicycle_control_fsm #(.HALT_ON_ILLEGAL(1'b0)) u_dut_cont (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .alu_op(alu_op0), .alu_src_a(a0), .alu_src_b(b0), .result_src(rs0),
        .adr_src(adr0), .imm_src(imm0), .ir_write(ir0), .pc_write(pc0),
        .reg_write(rw0), .mem_write(mw0), .illegal(ill0), .halted(hlt0)
    );

    multicycle_control_fsm #(.HALT_ON_ILLEGAL(1'b1)) u_dut_halt (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .alu_op(alu_op1), .alu_src_a(a1), .alu_src_b(b1), .result_src(rs1),
        .adr_src(adr1), .imm_src(imm1), .ir_write(ir1), .pc_write(pc1),
        .reg_write(rw1), .mem_write(mw1), .illegal(ill1), .halted(hlt1)
    );

    wire [16:0] out0 = {alu_op0, a0, b0, rs0, adr0, imm0, ir0, pc0, rw0, mw0, ill0, hlt0};
    wire [16:0] out1 = {alu_op1, a1, b1, rs1, adr1, imm1, ir1, pc1, rw1, mw1, ill1, hlt1};

    localparam int P_RST = 0, P_FETCH = 1, P_DEC = 2, P_MEMADR = 3, P_MEMREAD = 4,
                   P_MEMWB = 5, P_MEMWRITE = 6, P_EXECR = 7, P_EXECI = 8,
                   P_ALUWB = 9, P_BEQ = 10, P_JAL = 11, P_HALT = 12;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;

    int checks = 0;
    int errors = 0;
    int ir_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s op=%b got=%h exp=%h", tag, op, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] o);
        return o == OP_LW || o == OP_SW || o == OP_R || o == OP_I || o == OP_BEQ || o == OP_JAL;
    endfunction

    // Expected output word straight from the per-step behaviour table.
    function automatic logic [16:0] model(input int ph, input logic [6:0] o,
                                          input logic mr, input logic z);
        logic [1:0] aop, sa, sb, rs, imm;
        logic adr, ir, pc, rw, mw, ill, h;
        aop = 0; sa = 0; sb = 0; rs = 0; adr = 0; ir = 0; pc = 0;
        rw = 0; mw = 0; ill = 0; h = 0;
        imm = (o == OP_SW) ? 2'b01 : (o == OP_BEQ) ? 2'b10 : (o == OP_JAL) ? 2'b11 : 2'b00;
        case (ph)
            P_RST:      begin sb = 2'b10; rs = 2'b10; end
            P_FETCH:    begin sb = 2'b10; rs = 2'b10; ir = mr; pc = mr; end
            P_DEC:      begin sa = 2'b01; sb = 2'b01; ill = !is_legal(o); end
            P_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            P_MEMREAD:  adr = 1;
            P_MEMWB:    begin rs = 2'b01; rw = 1; end
            P_MEMWRITE: begin adr = 1; mw = 1; end
            P_EXECR:    begin sa = 2'b10; aop = 2'b10; end
            P_EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            P_ALUWB:    rw = 1;
            P_BEQ:      begin sa = 2'b10; aop = 2'b01; pc = z; end
            P_JAL:      begin sa = 2'b01; sb = 2'b10; pc = 1; end
            P_HALT:     h = 1;
            default:    ;
        endcase
        return {aop, sa, sb, rs, adr, imm, ir, pc, rw, mw, ill, h};
    endfunction

    task automatic step(input int p0, input int p1, input logic mr, input string tag);
        mem_ready = mr;
        #2;
        check_eq({tag, "_cont"}, out0, model(p0, op, mr, zero));
        check_eq({tag, "_halt"}, out1, model(p1, op, mr, zero));
        ir_seen += int'(ir0);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_step();
        rst = 1'b1;
        step(P_RST, P_RST, 1'($urandom), "reset");
        rst = 1'b0;
    endtask

    task automatic waited(input int p, input int stalls, input string tag);
        for (int i = 0; i < stalls; i++) step(p, p, 1'b0, tag);
        step(p, p, 1'b1, tag);
    endtask

    task automatic run_instr(input logic [6:0] o, input int fs, input int ms, input logic z);
        op = o;
        zero = z;
        ir_seen = 0;
        waited(P_FETCH, fs, "fetch");
        step(P_DEC, P_DEC, 1'($urandom), "decode");
        case (o)
            OP_LW: begin
                step(P_MEMADR, P_MEMADR, 1'($urandom), "memadr");
                waited(P_MEMREAD, ms, "memread");
                step(P_MEMWB, P_MEMWB, 1'($urandom), "memwb");
            end
            OP_SW: begin
                step(P_MEMADR, P_MEMADR, 1'($urandom), "memadr");
                waited(P_MEMWRITE, ms, "memwrite");
            end
            OP_R, OP_I: begin
                step(o == OP_R ? P_EXECR : P_EXECI, o == OP_R ? P_EXECR : P_EXECI,
                     1'($urandom), "exec");
                step(P_ALUWB, P_ALUWB, 1'($urandom), "aluwb");
            end
            OP_BEQ: step(P_BEQ, P_BEQ, 1'($urandom), "beq");
            OP_JAL: begin
                step(P_JAL, P_JAL, 1'($urandom), "jal");
                step(P_ALUWB, P_ALUWB, 1'($urandom), "aluwb");
            end
            default: begin
                // Continuing instance stalls in FETCH; halting instance must stay parked.
                for (int i = 0; i < 3; i++) step(P_FETCH, P_HALT, 1'b0, "post_illegal");
                rst_step();
            end
        endcase
        checks++;
        if (ir_seen != 1) begin
            errors++;
            $display("FAIL ir_pulses op=%b got=%0d exp=1", o, ir_seen);
        end
    endtask

    logic [6:0] legal_ops [6];

    initial begin
        legal_ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
        rst = 1'b1; op = OP_LW; zero = 1'b0; mem_ready = 1'b0; ir_seen = 0;
        @(posedge clk);
        #1;
        rst_step();
        rst_step();

        run_instr(OP_LW, 0, 0, 1'b0);
        run_instr(OP_LW, 2, 3, 1'b0);
        run_instr(OP_R, 0, 0, 1'b0);
        run_instr(OP_I, 1, 0, 1'b1);
        run_instr(OP_BEQ, 0, 0, 1'b1);
        run_instr(OP_BEQ, 0, 0, 1'b0);
        run_instr(OP_JAL, 0, 0, 1'b0);
        run_instr(OP_SW, 0, 1, 1'b0);
        run_instr(7'b1111111, 0, 0, 1'b0);

        // Reset while stalled in MEMREAD.
        op = OP_LW;
        step(P_FETCH, P_FETCH, 1'b1, "fetch");
        step(P_DEC, P_DEC, 1'b0, "decode");
        step(P_MEMADR, P_MEMADR, 1'b0, "memadr");
        step(P_MEMREAD, P_MEMREAD, 1'b0, "memread");
        rst_step();

        for (int n = 0; n < 300; n++) begin
            logic [6:0] o;
            if ($urandom_range(0, 9) == 0) begin
                do o = 7'($urandom); while (is_legal(o));
            end else begin
                o = legal_ops[$urandom_range(0, 5)];
            end
            run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
